layer4_vec_loader: RTL and testbench

Stream-to-parallel activation loader that sits in front of a layer-4 neuron node. It accepts one IEEE-754 single-precision activation per beat on a valid/ready stream and assembles N_IN beats into the parallel vector A0x..A14x that drives the node's multiply/adder-tree inputs. It then holds the vector stable while the node's ReLU output register captures the result, and emits a one-cycle `node_done` strobe marking the node output as valid for that frame.

---
 rtl/layer4_vec_loader.sv | 127 ++++++++++++
 tb/tb_layer4_vec_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer4_vec_loader.sv
// Stream-to-parallel activation loader for a layer-4 neuron node.
// Collects N_IN float32 beats into A0x..A14x, holds them SETTLE cycles, then pulses node_done.
module layer4_vec_loader #(
  parameter int N_IN   = 15,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] A0x,
  output logic [WIDTH-1:0] A1x,
  output logic [WIDTH-1:0] A2x,
  output logic [WIDTH-1:0] A3x,
  output logic [WIDTH-1:0] A4x,
  output logic [WIDTH-1:0] A5x,
  output logic [WIDTH-1:0] A6x,
  output logic [WIDTH-1:0] A7x,
  output logic [WIDTH-1:0] A8x,
  output logic [WIDTH-1:0] A9x,
  output logic [WIDTH-1:0] A10x,
  output logic [WIDTH-1:0] A11x,
  output logic [WIDTH-1:0] A12x,
  output logic [WIDTH-1:0] A13x,
  output logic [WIDTH-1:0] A14x,
  output logic             node_done,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       err_flags
);

  localparam int N_PORTS = 15;
  localparam int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q [N_PORTS];
  logic               accept;
  logic               last_idx;

  // s_ready depends on state only, so there is no path from s_valid.
  assign s_ready  = (state_q == FILL);
  assign accept   = s_valid && s_ready;
  assign last_idx = (idx_q == IDX_W'(N_IN - 1));

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && last_idx) state_d = HOLD;
      HOLD:    if (cnt_q == CNT_W'(SETTLE - 1)) state_d = DONE;
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // NOTE: the activation array is reset because a reset must hand the node an all-zero vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      node_done <= 1'b0;
      frame_cnt <= '0;
      err_flags <= '0;
      for (int k = 0; k < N_PORTS; k++) a_q[k] <= '0;
    end else begin
      node_done <= (state_d == DONE);
      if (state_d == DONE) frame_cnt <= frame_cnt + 16'd1;

      case (state_q)
        FILL: begin
          if (accept) begin
            if (last_idx) begin
              a_q[idx_q] <= s_data;
              idx_q      <= '0;
              cnt_q      <= '0;
              if (!s_last) err_flags[1] <= 1'b1;
            end else if (s_last) begin
              // Early last drops the whole frame rather than leaving a partial vector.
              for (int k = 0; k < N_PORTS; k++) a_q[k] <= '0;
              idx_q        <= '0;
              err_flags[0] <= 1'b1;
            end else begin
              a_q[idx_q] <= s_data;
              idx_q      <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD:    cnt_q <= cnt_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign A0x  = a_q[0];
  assign A1x  = a_q[1];
  assign A2x  = a_q[2];
  assign A3x  = a_q[3];
  assign A4x  = a_q[4];
  assign A5x  = a_q[5];
  assign A6x  = a_q[6];
  assign A7x  = a_q[7];
  assign A8x  = a_q[8];
  assign A9x  = a_q[9];
  assign A10x = a_q[10];
  assign A11x = a_q[11];
  assign A12x = a_q[12];
  assign A13x = a_q[13];
  assign A14x = a_q[14];

endmodule

// File: tb/tb_layer4_vec_loader.sv
// Bench for layer4_vec_loader: directed and random frames against a frame-level model,
// plus a second instance with SETTLE=3 for frame spacing.
module tb_layer4_vec_loader;

  localparam int N = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] a_out [N];
  logic        node_done;
  logic [15:0] frame_cnt;
  logic [1:0]  err_flags;

  logic [31:0] s_data3;
  logic        s_valid3;
  logic        s_last3;
  logic        s_ready3;
  logic [31:0] a3_out [N];
  logic        node_done3;
  logic [15:0] frame_cnt3;
  logic [1:0]  err_flags3;

  always #5 clk = ~clk;

  layer4_vec_loader #(.N_IN(15), .WIDTH(32), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .A0x(a_out[0]), .A1x(a_out[1]), .A2x(a_out[2]), .A3x(a_out[3]), .A4x(a_out[4]),
    .A5x(a_out[5]), .A6x(a_out[6]), .A7x(a_out[7]), .A8x(a_out[8]), .A9x(a_out[9]),
    .A10x(a_out[10]), .A11x(a_out[11]), .A12x(a_out[12]), .A13x(a_out[13]), .A14x(a_out[14]),
    .node_done(node_done), .frame_cnt(frame_cnt), .err_flags(err_flags)
  );

  layer4_vec_loader #(.N_IN(15), .WIDTH(32), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data3), .s_valid(s_valid3), .s_last(s_last3), .s_ready(s_ready3),
    .A0x(a3_out[0]), .A1x(a3_out[1]), .A2x(a3_out[2]), .A3x(a3_out[3]), .A4x(a3_out[4]),
    .A5x(a3_out[5]), .A6x(a3_out[6]), .A7x(a3_out[7]), .A8x(a3_out[8]), .A9x(a3_out[9]),
    .A10x(a3_out[10]), .A11x(a3_out[11]), .A12x(a3_out[12]), .A13x(a3_out[13]), .A14x(a3_out[14]),
    .node_done(node_done3), .frame_cnt(frame_cnt3), .err_flags(err_flags3)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int low3 = 0;
  bit run3 = 1'b0;
  int done3_q [$];

  // Frame-level reference state.
  logic [31:0] frame_data [N];
  logic [31:0] exp_a [N];
  logic [15:0] exp_frames;
  logic [1:0]  exp_err;
  int          acc_cyc;
  int          first_acc;
  int          last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (node_done) done_cnt++;
    if (node_done3) done3_q.push_back(cyc);
    if (run3 && !s_ready3) low3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (s_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout observed=%0d expected=%0d", 0, 1);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < N; k++) check($sformatf("%s_A%0d", tag, k), a_out[k], exp_a[k]);
    check({tag, "_err"}, 32'(err_flags), 32'(exp_err));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_frames = '0;
    exp_err    = '0;
    for (int k = 0; k < N; k++) exp_a[k] = '0;
  endtask

  // last_pos < 0 means no s_last in the frame; keep leaves s_valid high afterwards.
  task automatic run_frame(input string tag, input int last_pos, input bit keep);
    int d0 = done_cnt;
    for (int i = 0; i < N; i++) begin
      send_beat(frame_data[i], 1'(i == last_pos));
      if (i == 0) first_acc = acc_cyc;
      if (i == last_pos && i < N - 1) break;
    end
    last_acc = acc_cyc;
    if (!keep) s_valid = 1'b0;
    if (last_pos >= 0 && last_pos < N - 1) begin
      exp_err[0] = 1'b1;
      for (int k = 0; k < N; k++) exp_a[k] = '0;
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_no_done"}, 32'(done_cnt), 32'(d0));
      check({tag, "_ready"}, 32'(s_ready), 32'd1);
    end else begin
      if (last_pos != N - 1) exp_err[1] = 1'b1;
      for (int k = 0; k < N; k++) exp_a[k] = frame_data[k];
      exp_frames = exp_frames + 16'd1;
      check({tag, "_hold_ready"}, 32'(s_ready), 32'd0);
      check({tag, "_hold_done"}, 32'(node_done), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(node_done), 32'd1);
      check({tag, "_done_ready"}, 32'(s_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_once"}, 32'(node_done), 32'd0);
      check({tag, "_fill_ready"}, 32'(s_ready), 32'd1);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
      check({tag, "_done_total"}, 32'(done_cnt - d0), 32'd1);
    end
    check_state(tag);
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) frame_data[k] = $urandom;
  endtask

  initial begin
    int prev_last;
    int b3;
    bit acc;
    rst_n    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data3  = '0;
    s_valid3 = 1'b0;
    s_last3  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state.
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_done", 32'(node_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_state("rst");

    // All-ones frame.
    for (int k = 0; k < N; k++) frame_data[k] = 32'h3F800000;
    run_frame("ones", N - 1, 1'b0);

    // Index-valued frame, then back-to-back random frame with s_valid held high.
    for (int k = 0; k < N; k++) frame_data[k] = 32'(k);
    run_frame("index", N - 1, 1'b1);
    prev_last = last_acc;
    fill_random();
    run_frame("b2b", N - 1, 1'b0);
    check("b2b_first_accept_gap", 32'(first_acc - prev_last), 32'd3);

    // Early last on beat 4, then a well-formed frame.
    do_reset();
    fill_random();
    run_frame("early", 4, 1'b0);
    fill_random();
    run_frame("after_early", N - 1, 1'b0);

    // Missing s_last.
    do_reset();
    fill_random();
    run_frame("nolast", -1, 1'b0);

    // Reset after 7 accepted beats.
    do_reset();
    fill_random();
    run_frame("pre", N - 1, 1'b0);
    for (int i = 0; i < 7; i++) send_beat($urandom, 1'b0);
    s_valid = 1'b0;
    do_reset();
    check("midrst_ready", 32'(s_ready), 32'd1);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_state("midrst");
    fill_random();
    run_frame("post_rst", N - 1, 1'b0);

    // Random frames with a random early-last position in one of them.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame($sformatf("rand%0d", f), (f == 1) ? int'($urandom_range(0, N - 2)) : N - 1, 1'b0);
    end

    // SETTLE=3 instance, three frames with s_valid held high.
    b3 = 0;
    done3_q.delete();
    run3 = 1'b1;
    s_valid3 = 1'b1;
    for (int c = 0; c < 200 && b3 < 3 * N; c++) begin
      s_data3 = 32'(b3 % N);
      s_last3 = ((b3 % N) == N - 1);
      acc = s_ready3;
      @(posedge clk); #1;
      if (acc) b3++;
    end
    s_valid3 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run3 = 1'b0;
    check("s3_beats", 32'(b3), 32'(3 * N));
    check("s3_done_count", 32'(done3_q.size()), 32'd3);
    if (done3_q.size() == 3) begin
      check("s3_spacing0", 32'(done3_q[1] - done3_q[0]), 32'd19);
      check("s3_spacing1", 32'(done3_q[2] - done3_q[1]), 32'd19);
    end
    check("s3_frame_cnt", 32'(frame_cnt3), 32'd3);
    check("s3_ready_low", 32'(low3), 32'd12);
    check("s3_err", 32'(err_flags3), 32'd0);
    for (int k = 0; k < N; k++) check($sformatf("s3_A%0d", k), a3_out[k], 32'(k));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
